// File: rtl/sha2_kconst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sha2_kconst_seq_if
// Purpose  : Handshake and data bundle for the SHA-2 round-constant sequencer.
//            The master side issues start/abort/k_ready and consumes the K
//            stream. The slave side is the sequencer itself.
// Signals  : start, mode_512, abort, k_ready  (master -> slave)
//            k_valid, k_out[OUT_W], round_idx[7], last, busy, done
//                                             (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface sha2_kconst_seq_if #(
  parameter int OUT_W = 32
);
  logic             start;
  logic             mode_512;
  logic             abort;
  logic             k_ready;
  logic             k_valid;
  logic [OUT_W-1:0] k_out;
  logic [6:0]       round_idx;
  logic             last;
  logic             busy;
  logic             done;

  modport master (
    output start, mode_512, abort, k_ready,
    input  k_valid, k_out, round_idx, last, busy, done
  );

  modport slave (
    input  start, mode_512, abort, k_ready,
    output k_valid, k_out, round_idx, last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/sha2_kconst_seq.sv
`default_nettype none
// ============================================================================
// Module   : sha2_kconst_seq
// Purpose  : Streams the SHA-2 round constants K[0..N-1] one per cycle over a
//            valid/ready handshake. N = 64 for SHA-224/256 and N = 80 for
//            SHA-384/512.
// Config   : define SHA2_KCONST_SHA512_EN to build in the 80-entry 64-bit
//            table. mode_512=1 then selects it, and OUT_W must be 64. Without
//            the macro, mode_512 is ignored and only the 32-bit table exists.
// Ports    : clk, rst (sync, active-high)
//            bus (sha2_kconst_seq_if.slave): start, mode_512, abort, k_ready
//            in; k_valid, k_out, round_idx, last, busy, done out.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_kconst_seq #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  sha2_kconst_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

`ifdef SHA2_KCONST_SHA512_EN
  // The SHA-256 constants are the upper 32 bits of the first 64 entries, so
  // one table serves both modes.
  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
`else
  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  state_t           state;
  logic             mode_sel;   // latched table select
  logic [6:0]       last_idx;   // N-1 for the active table
  logic [6:0]       tbl_idx;    // round whose constant is loaded on the next edge
  logic [OUT_W-1:0] k_tbl;

`ifdef SHA2_KCONST_SHA512_EN
  logic [63:0] k64;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sel <= 1'b0;
    end else if (!bus.abort && state == IDLE && bus.start) begin
      mode_sel <= bus.mode_512;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode_512;
  assign mode_sel    = 1'b0;
`endif

  assign last_idx = mode_sel ? 7'd79 : 7'd63;

  // In LOAD the table is read at index 0; in STREAM it is read one ahead of
  // round_idx so the next constant is ready for the cycle after a transfer.
  always_comb begin
    tbl_idx = (state == STREAM) ? bus.round_idx + 7'd1 : 7'd0;
`ifdef SHA2_KCONST_SHA512_EN
    k64   = (tbl_idx < 7'd80) ? K512[tbl_idx] : 64'd0;
    k_tbl = mode_sel ? OUT_W'(k64) : OUT_W'(k64[63:32]);
`else
    k_tbl = OUT_W'(K256[tbl_idx[5:0]]);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.k_valid   <= 1'b0;
      bus.k_out     <= '0;
      bus.round_idx <= 7'd0;
      bus.last      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else if (bus.abort) begin
      // k_out and round_idx keep their values; only the control outputs drop.
      state       <= IDLE;
      bus.k_valid <= 1'b0;
      bus.last    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            state         <= LOAD;
            bus.busy      <= 1'b1;
            bus.round_idx <= 7'd0;
          end
        end
        LOAD: begin
          state         <= STREAM;
          bus.k_out     <= k_tbl;
          bus.round_idx <= 7'd0;
          bus.last      <= 1'b0;
          bus.k_valid   <= 1'b1;
        end
        STREAM: begin
          if (bus.k_valid && bus.k_ready) begin
            if (bus.last) begin
              state       <= DONE;
              bus.k_valid <= 1'b0;
              bus.last    <= 1'b0;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
            end else begin
              bus.k_out     <= k_tbl;
              bus.round_idx <= tbl_idx;
              bus.last      <= (tbl_idx == last_idx);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_kconst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_kconst_seq
// Purpose  : Directed self-checking bench for sha2_kconst_seq. Expected
//            constants are transcribed from FIPS 180-4 into a local table.
//            With SHA2_KCONST_SHA512_EN defined the bench runs at OUT_W=64
//            and adds a SHA-512 stream test.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_kconst_seq;

`ifdef SHA2_KCONST_SHA512_EN
  localparam int OUT_W       = 64;
  localparam bit IGNORE_MODE = 1'b0;
`else
  localparam int OUT_W       = 32;
  localparam bit IGNORE_MODE = 1'b1;  // mode_512 must be ignored in this build
`endif

  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  sha2_kconst_seq_if #(.OUT_W(OUT_W)) bus ();

  sha2_kconst_seq #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] kexp(input int i);
    logic [31:0] k;
    k = KREF[i];
    return OUT_W'(k);
  endfunction

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start and step through LOAD to the first valid beat.
  task automatic launch(input logic m512);
    bus.start    = 1'b1;
    bus.mode_512 = m512;
    tick();
    bus.start    = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 6;
    if (bus.k_valid !== 1'b0)   begin errors++; $display("FAIL reset_k_valid: got %b expected 0", bus.k_valid); end
    if (bus.k_out !== '0)       begin errors++; $display("FAIL reset_k_out: got %h expected 0", bus.k_out); end
    if (bus.round_idx !== 7'd0) begin errors++; $display("FAIL reset_round_idx: got %0d expected 0", bus.round_idx); end
    if (bus.last !== 1'b0)      begin errors++; $display("FAIL reset_last: got %b expected 0", bus.last); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    bus.k_ready  = 1'b1;
    bus.start    = 1'b1;
    bus.mode_512 = 1'b0;
    tick();
    bus.start = 1'b0;
    checks += 2;
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL load_k_valid: got %b expected 0", bus.k_valid); end
    if (bus.busy !== 1'b1)    begin errors++; $display("FAIL load_busy: got %b expected 1", bus.busy); end
    tick();
    for (int i = 0; i < 64; i++) begin
      checks += 4;
      if (bus.k_valid !== 1'b1)          begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.k_valid); end
      if (bus.round_idx !== 7'(i))       begin errors++; $display("FAIL stream_idx[%0d]: got %0d expected %0d", i, bus.round_idx, i); end
      if (bus.k_out !== kexp(i))         begin errors++; $display("FAIL stream_k[%0d]: got %h expected %h", i, bus.k_out, kexp(i)); end
      if (bus.last !== (i == 63))        begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", i, bus.last, (i == 63)); end
      tick();
    end
    checks += 3;
    if (bus.done !== 1'b1)    begin errors++; $display("FAIL stream_done: got %b expected 1", bus.done); end
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", bus.k_valid); end
    if (bus.busy !== 1'b0)    begin errors++; $display("FAIL stream_end_busy: got %b expected 0", bus.busy); end
    tick();
    checks += 2;
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL done_pulse_width: got %b expected 0", bus.done); end
    if (bus.k_out !== kexp(63)) begin errors++; $display("FAIL idle_k_hold: got %h expected %h", bus.k_out, kexp(63)); end
  endtask

  task automatic test_backpressure();
    int  exp_idx = 0;
    int  cyc = 0;
    bit  fin = 0;
    bit  xfer;
    launch(IGNORE_MODE);
    while (!fin && cyc < 400) begin
      bus.k_ready = (cyc % 2 == 0);
      xfer = 1'b0;
      if (bus.k_valid === 1'b1) begin
        checks += 3;
        if (bus.round_idx !== 7'(exp_idx)) begin errors++; $display("FAIL bp_idx: got %0d expected %0d", bus.round_idx, exp_idx); end
        if (bus.k_out !== kexp(exp_idx % 64)) begin errors++; $display("FAIL bp_k[%0d]: got %h expected %h", exp_idx, bus.k_out, kexp(exp_idx % 64)); end
        if (bus.last !== (exp_idx == 63))  begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", exp_idx, bus.last, (exp_idx == 63)); end
        xfer = bus.k_ready;
      end else if (bus.done === 1'b1) begin
        fin = 1'b1;
      end else begin
        checks++;
        errors++;
        $display("FAIL bp_gap: k_valid=%b done=%b at beat %0d, expected valid or done", bus.k_valid, bus.done, exp_idx);
      end
      if (!fin) begin
        tick();
        if (xfer) exp_idx++;
        cyc++;
      end
    end
    bus.k_ready = 1'b1;
    checks += 3;
    if (fin !== 1'b1)           begin errors++; $display("FAIL bp_timeout: done seen %b expected 1", fin); end
    if (exp_idx != 64)          begin errors++; $display("FAIL bp_beats: got %0d expected 64", exp_idx); end
    if (bus.k_out !== kexp(63)) begin errors++; $display("FAIL bp_final_k: got %h expected %h", bus.k_out, kexp(63)); end
    tick();
  endtask

  task automatic test_abort();
    int n = 0;
    bus.k_ready = 1'b1;
    launch(1'b0);
    while (bus.round_idx !== 7'd20 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.round_idx !== 7'd20) begin errors++; $display("FAIL abort_reach20: got %0d expected 20", bus.round_idx); end
    bus.k_ready = 1'b0;
    bus.abort   = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks += 3;
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.k_valid); end
    if (bus.busy !== 1'b0)    begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)    begin errors++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    tick();
    tick();
    checks += 2;
    if (bus.done !== 1'b0)    begin errors++; $display("FAIL abort_no_done: got %b expected 0", bus.done); end
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: got %b expected 0", bus.k_valid); end
    launch(1'b0);
    checks += 3;
    if (bus.k_valid !== 1'b1)    begin errors++; $display("FAIL restart_valid: got %b expected 1", bus.k_valid); end
    if (bus.round_idx !== 7'd0)  begin errors++; $display("FAIL restart_idx: got %0d expected 0", bus.round_idx); end
    if (bus.k_out !== kexp(0))   begin errors++; $display("FAIL restart_k: got %h expected %h", bus.k_out, kexp(0)); end
    // A start pulse while streaming must not disturb a stalled beat.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks += 2;
    if (bus.round_idx !== 7'd0) begin errors++; $display("FAIL stall_hold_idx: got %0d expected 0", bus.round_idx); end
    if (bus.k_out !== kexp(0))  begin errors++; $display("FAIL stall_hold_k: got %h expected %h", bus.k_out, kexp(0)); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    bus.k_ready = 1'b1;
    launch(1'b0);
    while (bus.round_idx !== 7'd40 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (bus.round_idx !== 7'd40) begin errors++; $display("FAIL rst_reach40: got %0d expected 40", bus.round_idx); end
    rst = 1'b1;
    tick();
    checks += 6;
    if (bus.k_valid !== 1'b0)   begin errors++; $display("FAIL midrst_valid: got %b expected 0", bus.k_valid); end
    if (bus.k_out !== '0)       begin errors++; $display("FAIL midrst_k: got %h expected 0", bus.k_out); end
    if (bus.round_idx !== 7'd0) begin errors++; $display("FAIL midrst_idx: got %0d expected 0", bus.round_idx); end
    if (bus.last !== 1'b0)      begin errors++; $display("FAIL midrst_last: got %b expected 0", bus.last); end
    if (bus.busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0)      begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
    rst = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b expected 0", bus.busy); end
    tick();
    checks++;
    if (bus.k_valid !== 1'b0) begin errors++; $display("FAIL start_abort_valid: got %b expected 0", bus.k_valid); end
    launch(1'b0);
    checks += 2;
    if (bus.round_idx !== 7'd0) begin errors++; $display("FAIL post_rst_idx: got %0d expected 0", bus.round_idx); end
    if (bus.k_out !== kexp(0))  begin errors++; $display("FAIL post_rst_k: got %h expected %h", bus.k_out, kexp(0)); end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
  endtask

`ifdef SHA2_KCONST_SHA512_EN
  task automatic test_sha512();
    int beats = 0;
    bus.k_ready = 1'b1;
    bus.start    = 1'b1;
    bus.mode_512 = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.mode_512 = 1'b0;  // the latched mode must persist
    tick();
    checks++;
    if (bus.k_out !== 64'h428a2f98d728ae22) begin errors++; $display("FAIL s512_k0: got %h expected 428a2f98d728ae22", bus.k_out); end
    while (bus.k_valid === 1'b1 && beats < 200) begin
      if (bus.round_idx == 7'd64) begin
        checks++;
        if (bus.k_out !== 64'hca273eceea26619c) begin errors++; $display("FAIL s512_k64: got %h expected ca273eceea26619c", bus.k_out); end
      end
      if (bus.last === 1'b1) begin
        checks += 2;
        if (bus.round_idx !== 7'd79)              begin errors++; $display("FAIL s512_last_idx: got %0d expected 79", bus.round_idx); end
        if (bus.k_out !== 64'h6c44198c4a475817)   begin errors++; $display("FAIL s512_k79: got %h expected 6c44198c4a475817", bus.k_out); end
      end
      tick();
      beats++;
    end
    checks += 2;
    if (beats != 80)       begin errors++; $display("FAIL s512_beats: got %0d expected 80", beats); end
    if (bus.done !== 1'b1) begin errors++; $display("FAIL s512_done: got %b expected 1", bus.done); end
    tick();
  endtask
`endif

  initial begin
    bus.start    = 1'b0;
    bus.mode_512 = 1'b0;
    bus.abort    = 1'b0;
    bus.k_ready  = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_abort();
    test_reset_midstream();
`ifdef SHA2_KCONST_SHA512_EN
    test_sha512();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha2_kconst_seq.md
SHA2_KCONST_SEQ -- requirements
Module: sha2_kconst_seq

Interface
REQ-001 SHALL have parameter OUT_W, default 32, K output width; legal values 32 or 64.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin round-constant stream; sampled only in IDLE.
REQ-005 SHALL have port mode_512  input  1  0 = SHA-224/256 table, 1 = SHA-384/512 table; latched on accepted start.
REQ-006 SHALL have port abort  input  1  terminate stream immediately.
REQ-007 SHALL have port k_ready  input  1  downstream accepts current K.
REQ-008 SHALL have port k_valid  output  1  k_out/round_idx valid.
REQ-009 SHALL have port k_out  output  OUT_W  current round constant.
REQ-010 SHALL have port round_idx  output  7  round number t of k_out.
REQ-011 SHALL have port last  output  1  high with k_valid on the final round.
REQ-012 SHALL have port busy  output  1  high in LOAD and STREAM.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, STREAM, DONE.
REQ-015 IDLE: start=1 SHALL latch mode, set t=0, go to LOAD; start outside IDLE SHALL be ignored.
REQ-016 LOAD: SHALL register K[0] into k_out and go to STREAM; first k_valid SHALL assert 2 cycles after start is sampled.
REQ-017 STREAM: transfer = k_valid & k_ready; each transfer SHALL advance t by 1 with next K presented the following cycle, no bubble (1 K/cycle sustained).
REQ-018 While k_valid & !k_ready, k_out, round_idx, last SHALL hold stable.
REQ-019 Round count N SHALL be 64 in 256-mode, 80 in 512-mode; last=1 exactly when t=N-1.
REQ-020 Transfer with last=1 SHALL go to DONE; DONE SHALL assert done for one cycle, deassert k_valid, return to IDLE.
REQ-021 256-mode K SHALL be the 64 FIPS 180-4 32-bit constants, zero-extended to OUT_W when OUT_W=64.
REQ-022 round_idx SHALL never exceed N-1; counter SHALL not wrap to 0 inside a stream.
REQ-023 abort=1 in any state SHALL force IDLE next cycle with k_valid=0, done=0, busy=0; abort has priority over start and transfer in the same cycle.
REQ-024 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-025 k_out SHALL retain its last value in IDLE (not cleared except by reset).

Reset
REQ-026 rst=1 SHALL force IDLE, t=0, latched mode=0, k_valid=0, k_out=0, round_idx=0, last=0, busy=0, done=0 on the next edge.
REQ-027 rst SHALL override start, abort and any in-progress stream; first stream after reset SHALL begin at t=0.

Configuration
REQ-028 Macro SHA2_KCONST_SHA512_EN defined SHALL compile in the 80-entry 64-bit SHA-512 table; mode_512=1 selects it and requires OUT_W=64.
REQ-029 Without SHA2_KCONST_SHA512_EN, mode_512 SHALL be ignored (treated 0), N=64 always, and no 64-bit table logic SHALL be synthesised.

Verification
REQ-030 OUT_W=32, start, k_ready=1 -> k_valid 2 cycles later, K[0]=428a2f98, K[1]=71374491, ..., K[63]=c67178f2 with last=1, done pulse next cycle, 64 consecutive beats.
REQ-031 Macro defined, OUT_W=64, mode_512=1 -> K[0]=428a2f98d728ae22, K[79]=6c44198c4a475817 with last=1 at round_idx=79.
REQ-032 256-mode, k_ready toggled 1/0 every cycle -> each K held while k_ready=0, no skipped/repeated round, sequence ends at c67178f2.
REQ-033 abort asserted at round_idx=20 with k_ready=0 -> next cycle k_valid=0, busy=0, no done; new start restarts at K[0]=428a2f98.
REQ-034 rst asserted mid-stream at round_idx=40 -> all outputs 0 next cycle; start in IDLE simultaneously with abort -> remains IDLE.
